rib_arbiter: RTL

Shared-bus arbiter and transaction sequencer between the core's three bus masters and the single memory/peripheral slave port. It grants one master at a time by fixed priority: JTAG debug, then load/store, then instruction fetch. It registers the selected command and drives it to the slave until acknowledge or timeout. It also produces the load/store and fetch wait requests that the pipeline hold controller uses to stall the pipeline.

---
 rtl/rib_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rib_arbiter.sv
// Fixed-priority bus arbiter (JTAG > load/store > fetch): registers the winning command,
// drives it to the single slave port and returns a one-cycle ack/err/rdata to its owner.
module rib_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  input  logic                m2_req_i,
  input  logic                m2_we_i,
  input  logic [ADDR_W-1:0]   m2_addr_i,
  input  logic [DATA_W-1:0]   m2_wdata_i,
  input  logic [DATA_W/8-1:0] m2_wstrb_i,
  output logic                m2_ack_o,
  output logic                m2_err_o,
  output logic [DATA_W-1:0]   m2_rdata_o,
  output logic                s_req_o,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  input  logic                s_ack_i,
  input  logic [DATA_W-1:0]   s_rdata_i,
  output logic                mem_wait_req_o,
  output logic                if_wait_req_o,
  output logic [1:0]          owner_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q;
  logic                grant_d;
  logic [1:0]          owner_d, owner_q;
  logic                we_d, we_q;
  logic [ADDR_W-1:0]   addr_d, addr_q;
  logic [DATA_W-1:0]   wdata_d, wdata_q;
  logic [DATA_W/8-1:0] wstrb_d, wstrb_q;
  logic                s_req_q;
  logic [7:0]          cnt_q;
  logic [2:0]          ack_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                timeout_hit;

  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  // Lowest-numbered requester wins; its command is what gets captured on grant.
  always_comb begin
    grant_d = 1'b1;
    owner_d = 2'd3;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    wstrb_d = '0;
    if (m0_req_i) begin
      owner_d = 2'd0;
      we_d    = m0_we_i;
      addr_d  = m0_addr_i;
      wdata_d = m0_wdata_i;
      wstrb_d = m0_wstrb_i;
    end else if (m1_req_i) begin
      owner_d = 2'd1;
      we_d    = m1_we_i;
      addr_d  = m1_addr_i;
      wdata_d = m1_wdata_i;
      wstrb_d = m1_wstrb_i;
    end else if (m2_req_i) begin
      owner_d = 2'd2;
      we_d    = m2_we_i;
      addr_d  = m2_addr_i;
      wdata_d = m2_wdata_i;
      wstrb_d = m2_wstrb_i;
    end else begin
      grant_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd3;
      s_req_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (grant_d) begin
            state_q <= BUSY;
            owner_q <= owner_d;
            s_req_q <= 1'b1;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 8'd1;
          // A slave ack in the final allowed cycle beats the timeout.
          if (s_ack_i || timeout_hit) begin
            state_q <= DONE;
            s_req_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            ack_q   <= 3'b001 << owner_q;
            err_q   <= ~s_ack_i;
            rdata_q <= (s_ack_i && !we_q) ? s_rdata_i : '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          owner_q <= 2'd3;
          ack_q   <= '0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_ack_o   = ack_q[0];
  assign m1_ack_o   = ack_q[1];
  assign m2_ack_o   = ack_q[2];
  assign m0_err_o   = ack_q[0] & err_q;
  assign m1_err_o   = ack_q[1] & err_q;
  assign m2_err_o   = ack_q[2] & err_q;
  assign m0_rdata_o = ack_q[0] ? rdata_q : '0;
  assign m1_rdata_o = ack_q[1] ? rdata_q : '0;
  assign m2_rdata_o = ack_q[2] ? rdata_q : '0;

  assign s_req_o   = s_req_q;
  assign s_we_o    = we_q;
  assign s_addr_o  = addr_q;
  assign s_wdata_o = wdata_q;
  assign s_wstrb_o = wstrb_q;
  assign owner_o   = owner_q;

  assign mem_wait_req_o = m1_req_i & ~ack_q[1];
  assign if_wait_req_o  = m2_req_i & ~ack_q[2];

endmodule
